// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle shared by the IFU, the LSU, the arbiter and the single-port memory.
// The master view belongs to the arbiter; the slave view is the units plus the memory.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            ifu_req;
  logic [AW-1:0]   ifu_addr;
  logic [DW-1:0]   ifu_rdata;
  logic            ifu_ready;

  logic            lsu_req;
  logic            lsu_we;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_wdata;
  logic [DW/8-1:0] lsu_wstrb;
  logic [DW-1:0]   lsu_rdata;
  logic            lsu_ready;

  logic            bus_err;
  logic            owner;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;

  modport master (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
    input  mem_rdata, mem_ack,
    output ifu_rdata, ifu_ready, lsu_rdata, lsu_ready,
    output bus_err, owner,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
    output mem_rdata, mem_ack,
    input  ifu_rdata, ifu_ready, lsu_rdata, lsu_ready,
    input  bus_err, owner,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between instruction fetch and load/store,
// with registered bus outputs, one-cycle ready strobes and a per-transaction abort timer.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_bus_arbiter_if.master    bus
);

  localparam int              TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   C_TMAX  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic            C_TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_owner;
  logic [TW-1:0]   r_timer;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW/8-1:0] r_mem_wstrb;
  logic [DW-1:0]   r_ifu_rdata;
  logic [DW-1:0]   r_lsu_rdata;
  logic            r_ifu_ready;
  logic            r_lsu_ready;
  logic            r_bus_err;

  logic            w_owner_next;
  logic [TW-1:0]   w_timer_next;
  logic            w_mem_req_next;
  logic            w_mem_we_next;
  logic [AW-1:0]   w_mem_addr_next;
  logic [DW-1:0]   w_mem_wdata_next;
  logic [DW/8-1:0] w_mem_wstrb_next;
  logic [DW-1:0]   w_ifu_rdata_next;
  logic [DW-1:0]   w_lsu_rdata_next;
  logic            w_ifu_ready_next;
  logic            w_lsu_ready_next;
  logic            w_bus_err_next;

  logic            w_ifu_pend;
  logic            w_lsu_pend;
  logic            w_grant_ifu;
  logic            w_grant_lsu;
  logic            w_ack;
  logic            w_expire;
  logic            w_finish;

  // A requester is invisible in its own ready cycle, so a held req is not re-granted immediately.
  assign w_ifu_pend  = bus.ifu_req & ~r_ifu_ready;
  assign w_lsu_pend  = bus.lsu_req & ~r_lsu_ready;
  assign w_grant_lsu = w_lsu_pend & (~w_ifu_pend | ~r_owner);
  assign w_grant_ifu = w_ifu_pend & ~w_grant_lsu;

  assign w_ack    = bus.mem_ack & r_mem_req;
  assign w_expire = C_TO_EN & (r_timer == C_TMAX);
  assign w_finish = w_ack | w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_timer     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
      r_ifu_ready <= 1'b0;
      r_lsu_ready <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_timer     <= w_timer_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_wstrb <= w_mem_wstrb_next;
      r_ifu_rdata <= w_ifu_rdata_next;
      r_lsu_rdata <= w_lsu_rdata_next;
      r_ifu_ready <= w_ifu_ready_next;
      r_lsu_ready <= w_lsu_ready_next;
      r_bus_err   <= w_bus_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_lsu) begin
          w_state_next = BUSY_LSU;
        end else if (w_grant_ifu) begin
          w_state_next = BUSY_IFU;
        end
      end
      BUSY_IFU, BUSY_LSU: begin
        if (w_finish) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_owner_next     = r_owner;
    w_timer_next     = r_timer;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_wstrb_next = r_mem_wstrb;
    w_ifu_rdata_next = r_ifu_rdata;
    w_lsu_rdata_next = r_lsu_rdata;
    w_ifu_ready_next = 1'b0;
    w_lsu_ready_next = 1'b0;
    w_bus_err_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_lsu) begin
          w_owner_next     = 1'b1;
          w_timer_next     = '0;
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = bus.lsu_we;
          w_mem_addr_next  = bus.lsu_addr;
          w_mem_wdata_next = bus.lsu_wdata;
          w_mem_wstrb_next = bus.lsu_wstrb;
        end else if (w_grant_ifu) begin
          w_owner_next     = 1'b0;
          w_timer_next     = '0;
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = 1'b0;
          w_mem_addr_next  = bus.ifu_addr;
          w_mem_wdata_next = '0;
          w_mem_wstrb_next = '0;
        end
      end
      BUSY_IFU, BUSY_LSU: begin
        // An ack on the expiry edge takes priority, so bus_err is only raised without ack.
        if (w_finish) begin
          w_mem_req_next = 1'b0;
          w_bus_err_next = ~w_ack;
          if (r_state == BUSY_LSU) begin
            w_lsu_ready_next = 1'b1;
            w_lsu_rdata_next = w_ack ? bus.mem_rdata : '0;
          end else begin
            w_ifu_ready_next = 1'b1;
            w_ifu_rdata_next = w_ack ? bus.mem_rdata : '0;
          end
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      default: begin
        w_mem_req_next = 1'b0;
      end
    endcase
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.ifu_rdata = r_ifu_rdata;
  assign bus.lsu_rdata = r_lsu_rdata;
  assign bus.ifu_ready = r_ifu_ready;
  assign bus.lsu_ready = r_lsu_ready;
  assign bus.bus_err   = r_bus_err;
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: bench-driven IFU/LSU requesters, a memory responder with
// a word-array model that predicts each transaction's outcome, and a ready-side scoreboard monitor.
module tb_mem_bus_arbiter;

  localparam int TO  = 4;
  localparam int NTX = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        who;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          vec = 0;
  int          miss = 0;
  int          ntx = 0;

  logic [31:0] mem_model [0:63];
  logic [31:0] exp_ifu_rdata = 32'h0;
  logic [31:0] exp_lsu_rdata = 32'h0;

  bit          resp_on = 1'b0;
  bit          mon_on = 1'b0;
  bit          force_no_ack = 1'b0;
  int          force_lat = -1;

  bit          in_txn = 1'b0;
  bit          prev_req = 1'b0;
  bit          last_grant = 1'b0;
  int          busy_n = 0;
  int          ack_at = 0;
  logic [31:0] ack_data = 32'h0;

  logic        snap_ifu_pend = 1'b0;
  logic        snap_lsu_pend = 1'b0;
  logic [31:0] snap_ifu_addr = 32'h0;
  logic [31:0] snap_lsu_addr = 32'h0;
  logic        snap_lsu_we = 1'b0;
  logic [31:0] snap_lsu_wdata = 32'h0;
  logic [3:0]  snap_lsu_wstrb = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_req"},   {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_mem_we"},    {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, bus.mem_wstrb}, 32'd0);
    chk({tag, "_ifu_rdata"}, bus.ifu_rdata, 32'd0);
    chk({tag, "_lsu_rdata"}, bus.lsu_rdata, 32'd0);
    chk({tag, "_ifu_ready"}, {31'd0, bus.ifu_ready}, 32'd0);
    chk({tag, "_lsu_ready"}, {31'd0, bus.lsu_ready}, 32'd0);
    chk({tag, "_bus_err"},   {31'd0, bus.bus_err}, 32'd0);
    chk({tag, "_owner"},     {31'd0, bus.owner}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  // Requests change only just after a rising edge, so the falling-edge snapshot is what the DUT samples next.
  initial forever begin
    @(negedge clk);
    snap_ifu_pend  = bus.ifu_req & ~bus.ifu_ready;
    snap_lsu_pend  = bus.lsu_req & ~bus.lsu_ready;
    snap_ifu_addr  = bus.ifu_addr;
    snap_lsu_addr  = bus.lsu_addr;
    snap_lsu_we    = bus.lsu_we;
    snap_lsu_wdata = bus.lsu_wdata;
    snap_lsu_wstrb = bus.lsu_wstrb;
  end

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      bit          ended;
      bit          exp_who;
      bit          t_we;
      int          lat;
      logic [31:0] t_addr;
      @(posedge clk);
      #1;
      ended = 1'b0;
      if (!resp_on) begin
        bus.mem_ack = 1'b0;
        in_txn = 1'b0;
        prev_req = 1'b0;
        continue;
      end
      if (in_txn) begin
        busy_n++;
        if ((ack_at != 0 && busy_n == ack_at) || busy_n == TO) begin
          chk("mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
          in_txn = 1'b0;
          ended = 1'b1;
        end else begin
          chk("mem_req_hold", {31'd0, bus.mem_req}, 32'd1);
        end
      end else if (!prev_req && (snap_ifu_pend || snap_lsu_pend)) begin
        chk("grant_taken", {31'd0, bus.mem_req}, 32'd1);
      end
      if (!in_txn && !ended && bus.mem_req === 1'b1) begin
        chk("grant_has_req", {31'd0, snap_ifu_pend | snap_lsu_pend}, 32'd1);
        if (snap_ifu_pend && snap_lsu_pend) exp_who = ~last_grant;
        else exp_who = snap_lsu_pend;
        last_grant = exp_who;
        chk("owner", {31'd0, bus.owner}, {31'd0, exp_who});
        if (exp_who) begin
          t_addr = snap_lsu_addr;
          t_we   = snap_lsu_we;
          chk("lsu_mem_addr",  bus.mem_addr, snap_lsu_addr);
          chk("lsu_mem_we",    {31'd0, bus.mem_we}, {31'd0, snap_lsu_we});
          chk("lsu_mem_wdata", bus.mem_wdata, snap_lsu_wdata);
          chk("lsu_mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, snap_lsu_wstrb});
        end else begin
          t_addr = snap_ifu_addr;
          t_we   = 1'b0;
          chk("ifu_mem_addr",  bus.mem_addr, snap_ifu_addr);
          chk("ifu_mem_we",    {31'd0, bus.mem_we}, 32'd0);
          chk("ifu_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        end
        if (force_no_ack) lat = 99;
        else if (force_lat >= 0) lat = force_lat;
        else lat = int'($urandom_range(0, 5));
        if (lat < TO) begin
          ack_at   = lat + 1;
          ack_data = mem_model[t_addr[7:2]];
          q.push_back({exp_who, 1'b0, ack_data});
          if (t_we) begin
            for (int b = 0; b < 4; b++) begin
              if (snap_lsu_wstrb[b]) mem_model[t_addr[7:2]][8*b +: 8] = snap_lsu_wdata[8*b +: 8];
            end
          end
        end else begin
          ack_at = 0;
          q.push_back({exp_who, 1'b1, 32'h0});
        end
        in_txn = 1'b1;
        busy_n = 0;
      end
      prev_req = bus.mem_req;
      // Outside a transaction the memory sometimes acks anyway; the arbiter must ignore it.
      if (in_txn && ack_at == busy_n + 1) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = ack_data;
      end else if (!in_txn && $urandom_range(0, 3) == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_on) begin
      if (bus.ifu_ready || bus.lsu_ready) begin
        chk("single_ready", {31'd0, bus.ifu_ready & bus.lsu_ready}, 32'd0);
        if (q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL unexpected_ready: got ifu_ready=%0d lsu_ready=%0d, required no strobe (none outstanding)",
                   bus.ifu_ready, bus.lsu_ready);
        end else begin
          e = q.pop_front();
          chk("ready_who", {31'd0, bus.lsu_ready}, {31'd0, e.who});
          chk("bus_err", {31'd0, bus.bus_err}, {31'd0, e.err});
          if (e.who) exp_lsu_rdata = e.rdata;
          else exp_ifu_rdata = e.rdata;
          ntx++;
          $display("txn %0d: %s err=%0d rdata=0x%08h", ntx, e.who ? "lsu" : "ifu", bus.bus_err,
                   e.who ? bus.lsu_rdata : bus.ifu_rdata);
        end
      end else begin
        chk("bus_err_idle", {31'd0, bus.bus_err}, 32'd0);
      end
      chk("ifu_rdata", bus.ifu_rdata, exp_ifu_rdata);
      chk("lsu_rdata", bus.lsu_rdata, exp_lsu_rdata);
    end
  end

  task automatic wait_ready(input bit who);
    bit done;
    bit dropped;
    done = 1'b0;
    dropped = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk);
      #1;
      if (who ? bus.lsu_ready : bus.ifu_ready) begin
        done = 1'b1;
      end else if (!dropped && bus.mem_req && (bus.owner == who) && $urandom_range(0, 3) == 0) begin
        if (who) bus.lsu_req = 1'b0;
        else bus.ifu_req = 1'b0;
        dropped = 1'b1;
      end
    end
    chk(who ? "lsu_ready_bound" : "ifu_ready_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic ifu_driver(input int n, input bit fixed, input logic [31:0] faddr);
    for (int t = 0; t < n; t++) begin
      int idle;
      idle = (t < 3) ? 0 : int'($urandom_range(0, 3));
      if (idle > 0) begin
        bus.ifu_req = 1'b0;
        repeat (idle) @(posedge clk);
        #1;
      end
      bus.ifu_addr = fixed ? faddr : rand_addr();
      bus.ifu_req  = 1'b1;
      wait_ready(1'b0);
    end
    bus.ifu_req = 1'b0;
  endtask

  task automatic lsu_driver(input int n);
    for (int t = 0; t < n; t++) begin
      int idle;
      idle = (t < 3) ? 0 : int'($urandom_range(0, 3));
      if (idle > 0) begin
        bus.lsu_req = 1'b0;
        repeat (idle) @(posedge clk);
        #1;
      end
      bus.lsu_addr  = rand_addr();
      bus.lsu_we    = 1'($urandom_range(0, 1));
      bus.lsu_wdata = $urandom;
      bus.lsu_wstrb = 4'($urandom_range(0, 15));
      bus.lsu_req   = 1'b1;
      wait_ready(1'b1);
    end
    bus.lsu_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    bus.ifu_req   = 1'b0;
    bus.ifu_addr  = 32'h0;
    bus.lsu_req   = 1'b0;
    bus.lsu_we    = 1'b0;
    bus.lsu_addr  = 32'h0;
    bus.lsu_wdata = 32'h0;
    bus.lsu_wstrb = 4'h0;
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset("post_rst");
    resp_on = 1'b1;
    mon_on  = 1'b1;

    // Both units request together straight out of reset: LSU must win first, then alternate.
    fork
      ifu_driver(NTX, 1'b0, 32'h0);
      lsu_driver(NTX);
    join

    repeat (4) @(posedge clk);
    #1;
    force_no_ack  = 1'b1;
    bus.lsu_addr  = 32'h0000_0100;
    bus.lsu_wdata = 32'hDEAD_BEEF;
    bus.lsu_wstrb = 4'b0011;
    bus.lsu_we    = 1'b1;
    bus.lsu_req   = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clk);
      #1;
      got = bus.mem_req;
    end
    chk("store_granted", {31'd0, got}, 32'd1);
    chk("store_mem_addr",  bus.mem_addr, 32'h0000_0100);
    chk("store_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("store_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'h3);
    chk("store_mem_we",    {31'd0, bus.mem_we}, 32'd1);

    // Reset lands mid-cycle while the store waits for an ack that never comes.
    @(posedge clk);
    #3;
    resp_on = 1'b0;
    mon_on  = 1'b0;
    bus.mem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    q.delete();
    last_grant    = 1'b0;
    in_txn        = 1'b0;
    prev_req      = 1'b0;
    exp_ifu_rdata = 32'h0;
    exp_lsu_rdata = 32'h0;
    force_no_ack  = 1'b0;
    bus.lsu_req   = 1'b0;
    bus.lsu_we    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    resp_on = 1'b1;
    mon_on  = 1'b1;
    force_lat = 0;
    mem_model[16] = 32'h0000_0013;
    ifu_driver(1, 1'b1, 32'h0000_0040);
    chk("fetch_ifu_rdata", bus.ifu_rdata, 32'h0000_0013);
    chk("fetch_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
